pid_incremental: RTL and testbench

- Downstream stage of the error shift register in the PSU PID loop.
- Consumes the newest, previous and oldest error taps once per control sample.
- Computes the velocity-form PID increment with one shared multiplier over three cycles, then accumulates the increment into a saturated duty-cycle command for the PWM stage.
- Control law: u[n] = u[n-1] + Kp*(e0-e1) + Ki*e0 + Kd*(e0-2e1+e2), scaled by 2^-FRAC_BITS.

---
 rtl/pid_pkg.sv | 29 ++
 rtl/pid_mac.sv | 35 +++
 rtl/pid_incremental.sv | 148 ++++++++++++++
 tb/tb_pid_incremental.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and helpers for the incremental (velocity-form) PID stage.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_I,
    MUL_D,
    UPDATE
  } pid_state_e;

  // Width of a difference term: ADC tap plus headroom for e0 - 2*e1 + e2.
  function automatic int unsigned term_w(input int unsigned adc_w);
    return adc_w + 2;
  endfunction

  // Accumulator width: three products of (adc_w+2) x (coef_w+1) bits never overflow it.
  function automatic int unsigned acc_w(input int unsigned adc_w, input int unsigned coef_w);
    return adc_w + coef_w + 5;
  endfunction

  // Saturate a signed value into [lo, hi].
  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Signed multiply-accumulate, time-shared across the P, I and D terms.
module pid_mac
  import pid_pkg::*;
#(
  parameter int unsigned A_W   = 10,
  parameter int unsigned B_W   = 9,
  parameter int unsigned ACC_W = 21
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int unsigned P_W = A_W + B_W;

  logic signed [P_W-1:0] prod_c;

  assign prod_c = a * b;

  // Accumulator: clear wins over enable.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod_c);
    end
  end

endmodule

// File: rtl/pid_incremental.sv
// Velocity-form PID: one shared multiplier over three cycles, then a saturated duty update.
module pid_incremental
  import pid_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = 8,
  parameter int unsigned COEF_WIDTH = 8,
  parameter int unsigned FRAC_BITS  = 4,
  parameter int unsigned OUT_WIDTH  = 10,
  parameter int          OUT_MAX    = 1000,
  parameter int          OUT_MIN    = 0,
  parameter int          OUT_INIT   = 0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic [ADC_WIDTH-1:0]  e_new,
  input  logic [ADC_WIDTH-1:0]  e_prev,
  input  logic [ADC_WIDTH-1:0]  e_old,
  input  logic [COEF_WIDTH-1:0] kp,
  input  logic [COEF_WIDTH-1:0] ki,
  input  logic [COEF_WIDTH-1:0] kd,
  output logic [OUT_WIDTH-1:0]  duty,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned TERM_W = term_w(ADC_WIDTH);
  localparam int unsigned GAIN_W = COEF_WIDTH + 1;
  localparam int unsigned ACC_W  = acc_w(ADC_WIDTH, COEF_WIDTH);

  pid_state_e state;

  logic [COEF_WIDTH-1:0]    kp_q, ki_q, kd_q;
  logic signed [TERM_W-1:0] e0_q, dp_q, dd_q;

  logic signed [TERM_W-1:0] e0_c, e1_c, e2_c, dp_c, dd_c;
  logic signed [TERM_W-1:0] mac_a_c;
  logic signed [GAIN_W-1:0] mac_b_c;
  logic                     mac_en_c, mac_clr_c;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  delta_c;
  int                       sum_c;
  logic [OUT_WIDTH-1:0]     duty_next_c;

  // Sign-extend the taps and form the proportional and derivative differences.
  assign e0_c = TERM_W'($signed(e_new));
  assign e1_c = TERM_W'($signed(e_prev));
  assign e2_c = TERM_W'($signed(e_old));
  assign dp_c = e0_c - e1_c;
  assign dd_c = e0_c - (e1_c <<< 1) + e2_c;

  // Steer the latched term/gain pair for the current phase into the shared MAC.
  always_comb begin
    mac_a_c  = '0;
    mac_b_c  = '0;
    mac_en_c = 1'b0;
    case (state)
      MUL_P: begin
        mac_a_c  = dp_q;
        mac_b_c  = $signed({1'b0, kp_q});
        mac_en_c = !clear;
      end
      MUL_I: begin
        mac_a_c  = e0_q;
        mac_b_c  = $signed({1'b0, ki_q});
        mac_en_c = !clear;
      end
      MUL_D: begin
        mac_a_c  = dd_q;
        mac_b_c  = $signed({1'b0, kd_q});
        mac_en_c = !clear;
      end
      default: ;
    endcase
  end

  assign mac_clr_c = (state == IDLE) && start && !clear;

  pid_mac #(
    .A_W   (TERM_W),
    .B_W   (GAIN_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (mac_clr_c),
    .en    (mac_en_c),
    .a     (mac_a_c),
    .b     (mac_b_c),
    .acc   (acc)
  );

  // Scale the increment (floor) and add it to the current duty without wrap, then saturate.
  always_comb begin
    delta_c     = acc >>> FRAC_BITS;
    sum_c       = int'(duty) + int'(delta_c);
    duty_next_c = OUT_WIDTH'(clamp(sum_c, OUT_MIN, OUT_MAX));
  end

  // Control FSM with latched operands and registered duty/valid/busy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      duty  <= OUT_WIDTH'(OUT_INIT);
      valid <= 1'b0;
      busy  <= 1'b0;
      kp_q  <= '0;
      ki_q  <= '0;
      kd_q  <= '0;
      e0_q  <= '0;
      dp_q  <= '0;
      dd_q  <= '0;
    end else if (clear) begin
      state <= IDLE;
      duty  <= OUT_WIDTH'(OUT_INIT);
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kp_q  <= kp;
            ki_q  <= ki;
            kd_q  <= kd;
            e0_q  <= e0_c;
            dp_q  <= dp_c;
            dd_q  <= dd_c;
            busy  <= 1'b1;
            state <= MUL_P;
          end
        end
        MUL_P:  state <= MUL_I;
        MUL_I:  state <= MUL_D;
        MUL_D:  state <= UPDATE;
        UPDATE: begin
          duty  <= duty_next_c;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_incremental.sv
// Directed testbench for pid_incremental with hand-computed duty values.
module tb_pid_incremental;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       clear;
  logic [7:0] e_new, e_prev, e_old;
  logic [7:0] kp, ki, kd;
  logic [9:0] duty;
  logic       valid;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  pid_incremental dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .start  (start),
    .clear  (clear),
    .e_new  (e_new),
    .e_prev (e_prev),
    .e_old  (e_old),
    .kp     (kp),
    .ki     (ki),
    .kd     (kd),
    .duty   (duty),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int kp_v, input int ki_v, input int kd_v,
                        input int e0, input int e1, input int e2);
    kp     = 8'(kp_v);
    ki     = 8'(ki_v);
    kd     = 8'(kd_v);
    e_new  = 8'(e0);
    e_prev = 8'(e1);
    e_old  = 8'(e2);
  endtask

  // Full transaction: start, scramble inputs afterwards, check timing and final duty.
  task automatic run_op(input string tag, input int kp_v, input int ki_v, input int kd_v,
                        input int e0, input int e1, input int e2, input int exp_duty);
    set_in(kp_v, ki_v, kd_v, e0, e1, e2);
    start = 1'b1;
    step();
    start = 1'b0;
    set_in(255, 255, 255, 127, -128, 127);
    check({tag, "_busy_t0"}, int'(busy), 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check({tag, "_novalid_early"}, int'(valid), 0);
    end
    step();
    check({tag, "_valid"}, int'(valid), 1);
    check({tag, "_duty"}, int'(duty), exp_duty);
    check({tag, "_busy_done"}, int'(busy), 0);
    step();
    check({tag, "_valid_1cyc"}, int'(valid), 0);
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #3;
    check("rst_duty", int'(duty), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    #9;
    n_rst = 1'b1;
    step();

    run_op("p_step",   16, 0, 0,  10, 0, 0,   10);
    run_op("i_pos",     0, 8, 0,   3, 0, 0,   11);
    run_op("i_neg",     0, 8, 0,  -3, 3, 0,    9);
    run_op("d_term",    0, 0, 16,  4, 2, 6,   15);
    run_op("zero_gain", 0, 0, 0,   9, 9, 9,   15);
    run_op("sat_big", 255, 0, 0, 127, 0, 0, 1000);
    run_op("to_995",   16, 0, 0,  -5, 0, 0,  995);
    run_op("sat_hi",   16, 0, 0,  20, 0, 0, 1000);
    run_op("sat_neg", 255, 0, 0, -128, 0, 0,   0);
    run_op("to_5",     16, 0, 0,   5, 0, 0,    5);
    run_op("sat_lo",   16, 0, 0, -20, 0, 0,    0);
    run_op("mixed",    16, 16, 16, 6, 2, 1,   13);
    run_op("floor_neg", 3, 0, 0,  -5, 0, 0,   12);

    // Second start two cycles in must be ignored.
    set_in(16, 0, 0, 8, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    set_in(16, 0, 0, 100, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("hs_busy_t2", int'(busy), 1);
    check("hs_novalid_t2", int'(valid), 0);
    step();
    check("hs_novalid_t3", int'(valid), 0);
    step();
    check("hs_valid_t4", int'(valid), 1);
    check("hs_duty", int'(duty), 20);
    check("hs_busy_t4", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hs_no_second_valid", int'(valid), 0);
      check("hs_no_restart", int'(busy), 0);
    end
    check("hs_duty_hold", int'(duty), 20);

    // Clear during MUL_D aborts and resets duty.
    set_in(16, 0, 0, 10, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_duty", int'(duty), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_valid", int'(valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("clr_no_valid", int'(valid), 0);
    end

    // Clear beats start in the same cycle.
    start = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    clear = 1'b0;
    check("clr_vs_start_busy", int'(busy), 0);
    step();

    // Async reset mid-computation.
    run_op("pre_rst", 16, 0, 0, 7, 0, 0, 7);
    set_in(16, 0, 0, 50, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_duty", int'(duty), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(valid), 0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("arst_no_valid", int'(valid), 0);
    end
    run_op("post_rst", 16, 0, 0, 3, 0, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
